// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path: adder error code, FSM
// state encoding and active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package calc_pkg;

  localparam logic [7:0] ERR_CODE = 8'hFF;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  // Digit table; codes above 9 cannot occur from a valid BCD digit and show blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Single BCD digit to active-low seven-segment pattern, with a blank override
// used for leading-zero suppression.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : seg_digit(i_digit);

endmodule

// File: rtl/result_bcd_display.sv
// Sequential shift-add-3 binary-to-BCD converter for the adder result, with
// error flagging. Optional seven-segment outputs are built when SEVEN_SEG_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold last result
// SHIFT  | one add-3/shift step per cycle, WIDTH steps total
module result_bcd_display
  import calc_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ERR_CODE = calc_pkg::ERR_CODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`ifdef SEVEN_SEG_EN
  ,
  output logic [6:0]       seg_hundreds,
  output logic [6:0]       seg_tens,
  output logic [6:0]       seg_ones
`endif
);

  localparam int SR_W = WIDTH + 12;

  state_t            r_state;
  logic [SR_W-1:0]   r_sr;
  logic [2:0]        r_cnt;
  logic              r_err_cap;
  logic              r_done;
  logic              r_err;
  logic [3:0]        r_bcd_h;
  logic [3:0]        r_bcd_t;
  logic [3:0]        r_bcd_o;

  logic [SR_W-1:0]   w_sr_adj;
  logic [SR_W-1:0]   w_sr_next;
  logic [3:0]        w_nxt_h;
  logic [3:0]        w_nxt_t;
  logic [3:0]        w_nxt_o;

  always_comb begin
    w_sr_adj = r_sr;
    for (int k = 0; k < 3; k++) begin
      if (r_sr[WIDTH + 4*k +: 4] >= 4'd5)
        w_sr_adj[WIDTH + 4*k +: 4] = r_sr[WIDTH + 4*k +: 4] + 4'd3;
    end
    w_sr_next = {w_sr_adj[SR_W-2:0], 1'b0};
  end

  assign w_nxt_h = w_sr_next[WIDTH+8 +: 4];
  assign w_nxt_t = w_sr_next[WIDTH+4 +: 4];
  assign w_nxt_o = w_sr_next[WIDTH   +: 4];

`ifdef SEVEN_SEG_EN
  logic [6:0] w_seg_h;
  logic [6:0] w_seg_t;
  logic [6:0] w_seg_o;
  logic [6:0] r_seg_h;
  logic [6:0] r_seg_t;
  logic [6:0] r_seg_o;
  logic       w_blank_h;
  logic       w_blank_t;

  assign w_blank_h = (w_nxt_h == 4'd0);
  assign w_blank_t = w_blank_h && (w_nxt_t == 4'd0);

  seg7_decoder u_dec_h (.i_digit(w_nxt_h), .i_blank(w_blank_h), .o_seg(w_seg_h));
  seg7_decoder u_dec_t (.i_digit(w_nxt_t), .i_blank(w_blank_t), .o_seg(w_seg_t));
  seg7_decoder u_dec_o (.i_digit(w_nxt_o), .i_blank(1'b0),      .o_seg(w_seg_o));

  // Error override sits after the decoders so E,r,r wins over the converted digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_h <= SEG_BLANK;
      r_seg_t <= SEG_BLANK;
      r_seg_o <= SEG_BLANK;
    end else if (r_state == ST_SHIFT && r_cnt == 3'(WIDTH-1)) begin
      r_seg_h <= r_err_cap ? SEG_E : w_seg_h;
      r_seg_t <= r_err_cap ? SEG_R : w_seg_t;
      r_seg_o <= r_err_cap ? SEG_R : w_seg_o;
    end
  end

  assign seg_hundreds = r_seg_h;
  assign seg_tens     = r_seg_t;
  assign seg_ones     = r_seg_o;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_err_cap <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_bcd_h   <= '0;
      r_bcd_t   <= '0;
      r_bcd_o   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sr      <= {12'b0, value};
            r_cnt     <= '0;
            r_err_cap <= (value == ERR_CODE);
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'(WIDTH-1)) begin
            r_bcd_h <= w_nxt_h;
            r_bcd_t <= w_nxt_t;
            r_bcd_o <= w_nxt_o;
            r_err   <= r_err_cap;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (r_state == ST_SHIFT);
  assign done         = r_done;
  assign err          = r_err;
  assign bcd_hundreds = r_bcd_h;
  assign bcd_tens     = r_bcd_t;
  assign bcd_ones     = r_bcd_o;

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display; segment checks apply when SEVEN_SEG_EN is defined.
module tb_result_bcd_display;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] value;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
`ifdef SEVEN_SEG_EN
  logic [6:0] seg_hundreds;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
`endif

  int n_pass;
  int n_total;

  result_bcd_display dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .value        (value),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones)
`ifdef SEVEN_SEG_EN
    ,
    .seg_hundreds (seg_hundreds),
    .seg_tens     (seg_tens),
    .seg_ones     (seg_ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] v);
    value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ticks until done is seen (bounded); reports ticks taken and busy-high samples.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc = 0;
    nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) nbusy++;
      tick();
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    value = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    n_total++;
    if ({busy, done, err} !== 3'b000)
      $display("FAIL reset_flags: got busy/done/err=%b expected 000", {busy, done, err});
    else n_pass++;
    n_total++;
    if ({bcd_hundreds, bcd_tens, bcd_ones} !== 12'h000)
      $display("FAIL reset_bcd: got %h expected 000", {bcd_hundreds, bcd_tens, bcd_ones});
    else n_pass++;
`ifdef SEVEN_SEG_EN
    n_total++;
    if ({seg_hundreds, seg_tens, seg_ones} !== {7'h7F, 7'h7F, 7'h7F})
      $display("FAIL reset_seg: got %h %h %h expected 7f 7f 7f", seg_hundreds, seg_tens, seg_ones);
    else n_pass++;
`endif
  endtask

  task automatic test_convert_127();
    int cyc, nb;
    do_start(8'd127);
    wait_done(cyc, nb);
    n_total++;
    if (cyc !== 8) $display("FAIL c127_latency: got %0d cycles expected 8", cyc);
    else n_pass++;
    n_total++;
    if (nb !== 8) $display("FAIL c127_busy_cycles: got %0d expected 8", nb);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL c127_busy_in_done: got %b expected 0", busy);
    else n_pass++;
    n_total++;
    if ({bcd_hundreds, bcd_tens, bcd_ones, err} !== {12'h127, 1'b0})
      $display("FAIL c127_bcd_err: got %h err=%b expected 127 err=0",
               {bcd_hundreds, bcd_tens, bcd_ones}, err);
    else n_pass++;
`ifdef SEVEN_SEG_EN
    n_total++;
    if ({seg_hundreds, seg_tens, seg_ones} !== {7'b1111001, 7'b0100100, 7'b1111000})
      $display("FAIL c127_seg: got %b %b %b expected 1111001 0100100 1111000",
               seg_hundreds, seg_tens, seg_ones);
    else n_pass++;
`endif
    tick();
    n_total++;
    if (done !== 1'b0) $display("FAIL c127_done_pulse_width: got %b expected 0", done);
    else n_pass++;
  endtask

  task automatic test_err_code();
    int cyc, nb;
    do_start(8'hFF);
    wait_done(cyc, nb);
    n_total++;
    if ({bcd_hundreds, bcd_tens, bcd_ones, err} !== {12'h255, 1'b1})
      $display("FAIL err_bcd_err: got %h err=%b expected 255 err=1",
               {bcd_hundreds, bcd_tens, bcd_ones}, err);
    else n_pass++;
`ifdef SEVEN_SEG_EN
    n_total++;
    if ({seg_hundreds, seg_tens, seg_ones} !== {7'b0000110, 7'b0101111, 7'b0101111})
      $display("FAIL err_seg: got %b %b %b expected 0000110 0101111 0101111",
               seg_hundreds, seg_tens, seg_ones);
    else n_pass++;
`endif
    tick();
  endtask

  task automatic test_small_and_zero();
    int cyc, nb;
    do_start(8'd5);
    wait_done(cyc, nb);
    n_total++;
    if ({bcd_hundreds, bcd_tens, bcd_ones, err} !== {12'h005, 1'b0})
      $display("FAIL five_bcd_err: got %h err=%b expected 005 err=0",
               {bcd_hundreds, bcd_tens, bcd_ones}, err);
    else n_pass++;
`ifdef SEVEN_SEG_EN
    n_total++;
    if ({seg_hundreds, seg_tens, seg_ones} !== {7'h7F, 7'h7F, 7'b0010010})
      $display("FAIL five_seg: got %b %b %b expected 1111111 1111111 0010010",
               seg_hundreds, seg_tens, seg_ones);
    else n_pass++;
`endif
    tick();
    do_start(8'd0);
    wait_done(cyc, nb);
    n_total++;
    if ({bcd_hundreds, bcd_tens, bcd_ones} !== 12'h000)
      $display("FAIL zero_bcd: got %h expected 000", {bcd_hundreds, bcd_tens, bcd_ones});
    else n_pass++;
`ifdef SEVEN_SEG_EN
    n_total++;
    if ({seg_hundreds, seg_tens, seg_ones} !== {7'h7F, 7'h7F, 7'b1000000})
      $display("FAIL zero_seg: got %b %b %b expected 1111111 1111111 1000000",
               seg_hundreds, seg_tens, seg_ones);
    else n_pass++;
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    do_start(8'd42);
    tick();
    tick();
    value = 8'd99;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, nb);
    n_total++;
    if (cyc !== 5) $display("FAIL ignore_latency: got %0d cycles expected 5", cyc);
    else n_pass++;
    n_total++;
    if ({bcd_hundreds, bcd_tens, bcd_ones} !== 12'h042)
      $display("FAIL ignore_bcd: got %h expected 042", {bcd_hundreds, bcd_tens, bcd_ones});
    else n_pass++;
    do_start(8'd99);
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b expected 1", busy);
    else n_pass++;
    wait_done(cyc, nb);
    n_total++;
    if (cyc !== 8) $display("FAIL b2b_latency: got %0d cycles after start expected 8", cyc);
    else n_pass++;
    n_total++;
    if ({bcd_hundreds, bcd_tens, bcd_ones} !== 12'h099)
      $display("FAIL b2b_bcd: got %h expected 099", {bcd_hundreds, bcd_tens, bcd_ones});
    else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    int seen;
    do_start(8'd100);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if ({busy, done, err} !== 3'b000)
      $display("FAIL abort_flags: got busy/done/err=%b expected 000", {busy, done, err});
    else n_pass++;
    n_total++;
    if ({bcd_hundreds, bcd_tens, bcd_ones} !== 12'h000)
      $display("FAIL abort_bcd: got %h expected 000", {bcd_hundreds, bcd_tens, bcd_ones});
    else n_pass++;
`ifdef SEVEN_SEG_EN
    n_total++;
    if ({seg_hundreds, seg_tens, seg_ones} !== {7'h7F, 7'h7F, 7'h7F})
      $display("FAIL abort_seg: got %h %h %h expected 7f 7f 7f", seg_hundreds, seg_tens, seg_ones);
    else n_pass++;
`endif
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", seen);
    else n_pass++;
    value = 8'd7;
    start = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_over_start: got busy=%b expected 0", busy);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    start = 1'b0;
    value = 8'd0;
    test_reset();
    test_convert_127();
    test_err_code();
    test_small_and_zero();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
